// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single memory request/response port between the
// instruction fetch unit (IFU) and the load/store unit (LSU). Only one memory
// transaction is in flight at a time; simultaneous requests alternate between
// the two requesters.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   ifu_req_valid/ready/addr  fetch request (read-only)
//   ifu_flush                 drop the response of the outstanding fetch
//   ifu_resp_valid/data       fetch response, single-cycle pulse, no backpressure
//   lsu_req_*                 load/store request (addr, wen, wdata, wmask)
//   lsu_resp_valid/data       load/store response, single-cycle pulse
//   mem_req_*                 registered memory request, held until mem_req_ready
//   mem_resp_valid/data       memory response, only honoured while waiting for it

`ifndef XLEN
`define XLEN 64
`endif

module mem_arbiter #(
  parameter int unsigned XLEN   = `XLEN,
  parameter int unsigned MASK_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  // IFU request / response
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_req_addr,
  input  logic              ifu_flush,
  output logic              ifu_resp_valid,
  output logic [XLEN-1:0]   ifu_resp_data,
  // LSU request / response
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [XLEN-1:0]   lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [XLEN-1:0]   lsu_req_wdata,
  input  logic [MASK_W-1:0] lsu_req_wmask,
  output logic              lsu_resp_valid,
  output logic [XLEN-1:0]   lsu_resp_data,
  // Memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [MASK_W-1:0] mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_grant_q, last_grant_d;
  logic              drop_q, drop_d;

  logic [XLEN-1:0]   req_addr_q, req_addr_d;
  logic              req_wen_q, req_wen_d;
  logic [XLEN-1:0]   req_wdata_q, req_wdata_d;
  logic [MASK_W-1:0] req_wmask_q, req_wmask_d;

  logic              ifu_resp_valid_q, ifu_resp_valid_d;
  logic [XLEN-1:0]   ifu_resp_data_q, ifu_resp_data_d;
  logic              lsu_resp_valid_q, lsu_resp_valid_d;
  logic [XLEN-1:0]   lsu_resp_data_q, lsu_resp_data_d;

  logic              grant_ifu, grant_lsu;
  logic              flush_hit;

  // On a tie the requester that did not win last time gets the port.
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | (last_grant_q == OwnIfu));
  assign grant_ifu = ifu_req_valid & ~grant_lsu;

  // A flush only matters while a fetch owns the memory port.
  assign flush_hit = ifu_flush & (owner_q == OwnIfu);

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    drop_d           = drop_q;
    req_addr_d       = req_addr_q;
    req_wen_d        = req_wen_q;
    req_wdata_d      = req_wdata_q;
    req_wmask_d      = req_wmask_q;
    ifu_resp_valid_d = 1'b0;
    ifu_resp_data_d  = ifu_resp_data_q;
    lsu_resp_valid_d = 1'b0;
    lsu_resp_data_d  = lsu_resp_data_q;
    ifu_req_ready    = 1'b0;
    lsu_req_ready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        drop_d        = 1'b0;
        ifu_req_ready = grant_ifu;
        lsu_req_ready = grant_lsu;
        // ready equals grant, so a grant is also the handshake
        if (grant_lsu) begin
          req_addr_d   = lsu_req_addr;
          req_wen_d    = lsu_req_wen;
          req_wdata_d  = lsu_req_wdata;
          req_wmask_d  = lsu_req_wmask;
          owner_d      = OwnLsu;
          last_grant_d = OwnLsu;
          state_d      = StIssue;
        end else if (grant_ifu) begin
          req_addr_d   = ifu_req_addr;
          req_wen_d    = 1'b0;
          req_wdata_d  = '0;
          req_wmask_d  = '0;
          owner_d      = OwnIfu;
          last_grant_d = OwnIfu;
          state_d      = StIssue;
        end
      end

      StIssue: begin
        if (flush_hit) begin
          drop_d = 1'b1;
        end
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (flush_hit) begin
          drop_d = 1'b1;
        end
        if (mem_resp_valid) begin
          state_d = StIdle;
          drop_d  = 1'b0;
          if (owner_q == OwnLsu) begin
            lsu_resp_valid_d = 1'b1;
            lsu_resp_data_d  = mem_resp_data;
          end else if (!(drop_q || flush_hit)) begin
            // A flush in the very cycle of the response still drops it.
            ifu_resp_valid_d = 1'b1;
            ifu_resp_data_d  = mem_resp_data;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      owner_q          <= OwnIfu;
      last_grant_q     <= OwnLsu;
      drop_q           <= 1'b0;
      req_addr_q       <= '0;
      req_wen_q        <= 1'b0;
      req_wdata_q      <= '0;
      req_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_resp_data_q  <= '0;
      lsu_resp_valid_q <= 1'b0;
      lsu_resp_data_q  <= '0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      drop_q           <= drop_d;
      req_addr_q       <= req_addr_d;
      req_wen_q        <= req_wen_d;
      req_wdata_q      <= req_wdata_d;
      req_wmask_q      <= req_wmask_d;
      ifu_resp_valid_q <= ifu_resp_valid_d;
      ifu_resp_data_q  <= ifu_resp_data_d;
      lsu_resp_valid_q <= lsu_resp_valid_d;
      lsu_resp_data_q  <= lsu_resp_data_d;
    end
  end

  assign mem_req_valid  = (state_q == StIssue);
  assign mem_req_addr   = req_addr_q;
  assign mem_req_wen    = req_wen_q;
  assign mem_req_wdata  = req_wdata_q;
  assign mem_req_wmask  = req_wmask_q;

  assign ifu_resp_valid = ifu_resp_valid_q;
  assign ifu_resp_data  = ifu_resp_data_q;
  assign lsu_resp_valid = lsu_resp_valid_q;
  assign lsu_resp_data  = lsu_resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.

module tb_mem_arbiter;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned MASK_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ifu_req_valid = 1'b0;
  logic              ifu_req_ready;
  logic [XLEN-1:0]   ifu_req_addr = '0;
  logic              ifu_flush = 1'b0;
  logic              ifu_resp_valid;
  logic [XLEN-1:0]   ifu_resp_data;
  logic              lsu_req_valid = 1'b0;
  logic              lsu_req_ready;
  logic [XLEN-1:0]   lsu_req_addr = '0;
  logic              lsu_req_wen = 1'b0;
  logic [XLEN-1:0]   lsu_req_wdata = '0;
  logic [MASK_W-1:0] lsu_req_wmask = '0;
  logic              lsu_resp_valid;
  logic [XLEN-1:0]   lsu_resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic [XLEN-1:0]   mem_req_addr;
  logic              mem_req_wen;
  logic [XLEN-1:0]   mem_req_wdata;
  logic [MASK_W-1:0] mem_req_wmask;
  logic              mem_resp_valid = 1'b0;
  logic [XLEN-1:0]   mem_resp_data = '0;

  mem_arbiter #(
    .XLEN   (XLEN),
    .MASK_W (MASK_W)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_req_addr   (ifu_req_addr),
    .ifu_flush      (ifu_flush),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_data  (ifu_resp_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_req_addr   (lsu_req_addr),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_wdata  (lsu_req_wdata),
    .lsu_req_wmask  (lsu_req_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: at most one transaction, described by its owner,
  // its request fields, whether memory accepted it and whether it was flushed.
  bit          m_busy, m_sent, m_drop, m_own, m_last;
  logic [63:0] m_addr, m_wdata;
  bit          m_wen;
  logic [7:0]  m_wmask;
  bit          e_irv, e_lrv;
  logic [63:0] e_ird, e_lrd;

  task automatic model_reset();
    m_busy = 0; m_sent = 0; m_drop = 0; m_own = 0; m_last = 1;
    m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0;
    e_irv = 0; e_lrv = 0; e_ird = '0; e_lrd = '0;
  endtask

  // One clock cycle: drive inputs after the falling edge, compare, advance model.
  task automatic step(input bit iv, input logic [63:0] ia, input bit lv, input logic [63:0] la,
                      input bit lw, input logic [63:0] lwd, input logic [7:0] lwm,
                      input bit fl, input bit mrdy, input bit mrv, input logic [63:0] mrd,
                      input bit r);
    bit g_i, g_l;
    @(negedge clk);
    ifu_req_valid = iv; ifu_req_addr = ia; ifu_flush = fl;
    lsu_req_valid = lv; lsu_req_addr = la; lsu_req_wen = lw;
    lsu_req_wdata = lwd; lsu_req_wmask = lwm;
    mem_req_ready = mrdy; mem_resp_valid = mrv; mem_resp_data = mrd;
    rst = r;
    #1;
    if (r) model_reset();
    g_l = !m_busy && lv && (!iv || !m_last);
    g_i = !m_busy && iv && !g_l;
    if (!r) begin
      check_eq("ifu_req_ready", ifu_req_ready, g_i);
      check_eq("lsu_req_ready", lsu_req_ready, g_l);
    end
    check_eq("mem_req_valid", mem_req_valid, m_busy && !m_sent);
    check_eq("mem_req_addr", mem_req_addr, m_addr);
    check_eq("mem_req_wen", mem_req_wen, m_wen);
    check_eq("mem_req_wmask", mem_req_wmask, m_wmask);
    if (m_busy && m_own) check_eq("mem_req_wdata", mem_req_wdata, m_wdata);
    check_eq("ifu_resp_valid", ifu_resp_valid, e_irv);
    check_eq("ifu_resp_data", ifu_resp_data, e_ird);
    check_eq("lsu_resp_valid", lsu_resp_valid, e_lrv);
    check_eq("lsu_resp_data", lsu_resp_data, e_lrd);
    if (!r) begin
      e_irv = 0;
      e_lrv = 0;
      if (m_busy) begin
        if (fl && !m_own) m_drop = 1;
        if (m_sent) begin
          if (mrv) begin
            m_busy = 0;
            if (m_own) begin
              e_lrv = 1; e_lrd = mrd;
            end else if (!m_drop) begin
              e_irv = 1; e_ird = mrd;
            end
            m_drop = 0;
          end
        end else if (mrdy) begin
          m_sent = 1;
        end
      end else if (g_l || g_i) begin
        m_busy  = 1;
        m_sent  = 0;
        m_drop  = 0;
        m_own   = g_l;
        m_last  = g_l;
        m_addr  = g_l ? la : ia;
        m_wen   = g_l ? lw : 1'b0;
        m_wdata = g_l ? lwd : 64'd0;
        m_wmask = g_l ? lwm : 8'd0;
      end
    end
  endtask

  task automatic idle1(input bit mrdy, input bit mrv, input logic [63:0] mrd);
    step(0, 0, 0, 0, 0, 0, 0, 0, mrdy, mrv, mrd, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  int grants[$];
  logic [63:0] addrs[$];

  initial begin
    model_reset();

    // Single fetch, fastest memory: response pulse three cycles after handshake.
    do_reset();
    step(1, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t_fetch_hs", ifu_req_ready, 1);
    idle1(1, 0, 0);
    check_eq("t_fetch_issue_addr", mem_req_addr, 64'h8000_0000);
    idle1(0, 1, 64'h0000_0413);
    check_eq("t_fetch_c2_rv", ifu_resp_valid, 0);
    idle1(0, 0, 0);
    check_eq("t_fetch_c3_rv", ifu_resp_valid, 1);
    check_eq("t_fetch_c3_rd", ifu_resp_data, 64'h0000_0413);
    check_eq("t_fetch_c3_lsu", lsu_resp_valid, 0);
    idle1(0, 0, 0);
    check_eq("t_fetch_pulse_end", ifu_resp_valid, 0);

    // Both requesting continuously: IFU, LSU, IFU, LSU.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1, 64'hA000, 1, 64'hB000, 0, 0, 0, 0, 1, 1, 64'(k), 0);
      if (ifu_req_ready) grants.push_back(0);
      if (lsu_req_ready) grants.push_back(1);
      if (mem_req_valid) addrs.push_back(mem_req_addr);
    end
    for (int i = 0; i < 4; i++) begin
      check_eq("t_alt_grant", (i < grants.size()) ? grants[i] : 2, i % 2);
      check_eq("t_alt_addr", (i < addrs.size()) ? addrs[i] : 64'hFFFF,
               (i % 2) ? 64'hB000 : 64'hA000);
    end

    // LSU write with memory stalled for four cycles.
    do_reset();
    step(0, 0, 1, 64'h8000_1000, 1, 64'h1122_3344_5566_7788, 8'h0F, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 64'h5000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_eq("t_stall_valid", mem_req_valid, 1);
      check_eq("t_stall_addr", mem_req_addr, 64'h8000_1000);
      check_eq("t_stall_wen", mem_req_wen, 1);
      check_eq("t_stall_wdata", mem_req_wdata, 64'h1122_3344_5566_7788);
      check_eq("t_stall_wmask", mem_req_wmask, 8'h0F);
      check_eq("t_stall_irdy", ifu_req_ready, 0);
      check_eq("t_stall_lrdy", lsu_req_ready, 0);
    end
    step(1, 64'h5000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    step(1, 64'h5000, 0, 0, 0, 0, 0, 0, 0, 1, 64'hDEAD, 0);
    check_eq("t_stall_wait_irdy", ifu_req_ready, 0);
    idle1(0, 0, 0);
    check_eq("t_stall_lsu_rv", lsu_resp_valid, 1);
    check_eq("t_stall_lsu_rd", lsu_resp_data, 64'hDEAD);

    // Flush during WAIT drops the fetch response; next fetch proceeds normally.
    do_reset();
    step(1, 64'h8000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle1(1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    idle1(0, 1, 64'h1234);
    step(1, 64'h8000_0200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t_flush_rv", ifu_resp_valid, 0);
    check_eq("t_flush_next_rdy", ifu_req_ready, 1);
    idle1(1, 0, 0);
    check_eq("t_flush_next_addr", mem_req_addr, 64'h8000_0200);
    idle1(0, 1, 64'h5678);
    idle1(0, 0, 0);
    check_eq("t_flush_cleared_rv", ifu_resp_valid, 1);

    // Reset in WAIT, late memory response afterwards.
    do_reset();
    step(1, 64'h8000_0300, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle1(1, 0, 0);
    idle1(0, 0, 0);
    do_reset();
    idle1(0, 1, 64'h9999);
    idle1(0, 0, 0);
    check_eq("t_rst_irv", ifu_resp_valid, 0);
    check_eq("t_rst_lrv", lsu_resp_valid, 0);
    check_eq("t_rst_mvalid", mem_req_valid, 0);
    check_eq("t_rst_maddr", mem_req_addr, 0);
    check_eq("t_rst_ird", ifu_resp_data, 0);

    // Stray memory response while idle.
    do_reset();
    idle1(0, 1, 64'hBAD);
    idle1(0, 0, 0);
    check_eq("t_stray_irv", ifu_resp_valid, 0);
    check_eq("t_stray_lrv", lsu_resp_valid, 0);
    step(0, 0, 1, 64'h40, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("t_stray_idle_rdy", lsu_req_ready, 1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(1'($urandom % 2), {$urandom, $urandom}, 1'($urandom % 2), {$urandom, $urandom},
           1'($urandom % 2), {$urandom, $urandom}, 8'($urandom),
           ($urandom % 8) == 0, 1'($urandom % 2), ($urandom % 3) == 0,
           {$urandom, $urandom}, ($urandom % 250) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter: XLEN, default `XLEN (64), meaning address/data width.
REQ-002 The block SHALL have parameter: MASK_W, default XLEN/8, meaning byte write-mask width.
REQ-003 The block SHALL have port: clk  in  1  sole clock, rising edge.
REQ-004 The block SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports: ifu_req_valid  in  1; ifu_req_ready  out  1; ifu_req_addr  in  XLEN  (fetch request, read-only).
REQ-006 The block SHALL have ports: ifu_flush  in  1  (discard outstanding fetch response); ifu_resp_valid  out  1; ifu_resp_data  out  XLEN.
REQ-007 The block SHALL have ports: lsu_req_valid  in  1; lsu_req_ready  out  1; lsu_req_addr  in  XLEN; lsu_req_wen  in  1; lsu_req_wdata  in  XLEN; lsu_req_wmask  in  MASK_W.
REQ-008 The block SHALL have ports: lsu_resp_valid  out  1; lsu_resp_data  out  XLEN.
REQ-009 The block SHALL have ports: mem_req_valid  out  1; mem_req_ready  in  1; mem_req_addr  out  XLEN; mem_req_wen  out  1; mem_req_wdata  out  XLEN; mem_req_wmask  out  MASK_W; mem_resp_valid  in  1; mem_resp_data  in  XLEN.

Function
REQ-010 The block SHALL share one memory port between IFU and LSU, with exactly one transaction outstanding at a time.
REQ-011 The FSM SHALL have states IDLE, ISSUE and WAIT, plus an owner register (IFU/LSU) and a last_grant register.
REQ-012 In IDLE, the block SHALL grant LSU when only LSU is valid and IFU when only IFU is valid; when both are valid, it SHALL grant the requester not equal to last_grant.
REQ-013 In IDLE, the block SHALL drive the granted requester's req_ready to 1 combinationally; all other req_ready outputs SHALL be 0; in ISSUE and WAIT, both req_ready outputs SHALL be 0.
REQ-014 On a valid&ready handshake, the block SHALL register addr/wen/wdata/wmask (IFU: wen=0, wmask=0), set owner and last_grant, and go to ISSUE.
REQ-015 In ISSUE, mem_req_valid SHALL be 1 and the mem_req_* outputs SHALL come from registers, held stable until mem_req_ready; on mem_req_ready the FSM SHALL go to WAIT.
REQ-016 In WAIT, on mem_resp_valid the block SHALL capture mem_resp_data, pulse the owner's resp_valid for exactly 1 cycle in the next cycle with resp_data, and go to IDLE.
REQ-017 Minimum latency SHALL be 3 cycles from request handshake to resp_valid (mem_req_ready and mem_resp_valid both ready immediately); the next grant SHALL be possible in the cycle resp_valid is high.
REQ-018 Responses SHALL have no backpressure; the requester SHALL accept them unconditionally.
REQ-019 mem_resp_valid outside WAIT SHALL be ignored, with no state change and no resp pulse.
REQ-020 When ifu_flush=1 while owner=IFU in ISSUE or WAIT, the block SHALL set a drop flag; the transaction SHALL complete at memory, but ifu_resp_valid SHALL stay 0 for it; the drop flag SHALL clear on return to IDLE.
REQ-021 ifu_flush in IDLE SHALL have no effect; ifu_flush when owner=LSU SHALL have no effect.
REQ-022 A flush coinciding with the mem_resp_valid cycle SHALL still drop the response.
REQ-023 resp_data SHALL hold its last value when resp_valid=0.

Reset
REQ-024 On rst=1 (asynchronous), the block SHALL force state=IDLE, owner=IFU, last_grant=LSU (so IFU wins the first tie), drop=0, all *_resp_valid=0, all resp_data=0, mem_req_valid=0, and registered mem_req_* = 0.
REQ-025 Reset asserted mid-transaction SHALL abandon the transaction; no resp pulse SHALL follow; a late mem_resp_valid after reset SHALL be ignored (REQ-019).

Verification
REQ-026 Bench SHALL cover: IFU-only, addr=0x80000000, mem_req_ready=1 and mem_resp_valid one cycle after issue with data 0x00000413 -> ifu_resp_valid pulse at cycle 3 with data 0x00000413, lsu_resp_valid stays 0.
REQ-027 Bench SHALL cover: both valid continuously after reset -> grants IFU, LSU, IFU, LSU in that order; mem_req_addr alternates accordingly.
REQ-028 Bench SHALL cover: LSU write addr=0x80001000, wdata=0x1122334455667788, wmask=0x0F, mem_req_ready held 0 for 4 cycles -> mem_req_* stable throughout, both req_ready=0 until response.
REQ-029 Bench SHALL cover: IFU fetch outstanding, ifu_flush pulsed in WAIT -> mem response consumed, no ifu_resp_valid, FSM in IDLE next cycle, next IFU request granted.
REQ-030 Bench SHALL cover: rst asserted during WAIT, mem_resp_valid arrives after deassert -> all outputs 0, no resp pulse.
REQ-031 Bench SHALL cover: stray mem_resp_valid in IDLE -> no resp pulse, state unchanged.
